fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Two-port write arbiter that shares the single write port of the SPI FIFO between two producers (e.g. register-file and SPI-slave shift path). Each producer presents words on a valid/ready handshake; the arbiter selects one word per cycle with burst-limited round-robin fairness and drives registered `wr_en`/`data_in` into the FIFO. It uses `full`/`almostfull` to guarantee no write is issued that can overflow, and checks the FIFO's `wr_ack`/`overflow` responses.

## Interface
- `WIDTH`, 16, data word width (matches FIFO `data_in`)
- `BURST`, 4, max consecutive grants to one requester while the other is waiting (1..15)
- `clk`  input  1  system clock, all logic on rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `req0_valid` / `req1_valid`  input  1  producer has a word
- `req0_data` / `req1_data`  input  WIDTH  producer word
- `req0_ready` / `req1_ready`  output  1  word accepted this cycle when valid & ready (combinational)
- `fifo_full`  input  1  FIFO `full`
- `fifo_almostfull`  input  1  FIFO `almostfull` (exactly one free slot)
- `fifo_wr_ack`  input  1  FIFO `wr_ack`
- `fifo_overflow`  input  1  FIFO `overflow`
- `fifo_wr_en`  output  1  registered write strobe to FIFO
- `fifo_data_in`  output  WIDTH  registered write data to FIFO
- `grant_id`  output  1  requester that owns the word currently on `fifo_data_in`
- `wr_count`  output  16  number of `fifo_wr_ack` pulses seen, wraps at 0xFFFF→0
- `ovf_err`  output  1  sticky: an overflow response was seen
- `clr_err`  input  1  synchronous clear of `ovf_err`

## Operation
- Issue permission in cycle c: `can_issue = !fifo_full && (!fifo_wr_en || !fifo_almostfull)`. `fifo_wr_en` high in c means a write not yet reflected in the flags; with `almostfull` high it would consume the last slot, so the arbiter holds.
- If `can_issue` = 0: both readies 0, `fifo_wr_en` deasserts next cycle.
- Arbitration when `can_issue`: state = `last` (requester last granted, reset 1) and `burst_cnt` (4 bits, reset 0).
  - Only one requester valid → grant it.
  - Both valid: if `last` valid and `burst_cnt < BURST` → grant `last`; else grant `!last`.
  - Grant to same requester as `last` → `burst_cnt`+1 (saturating at BURST); grant to other → `last` updated, `burst_cnt` = 1.
  - No valid requester → no grant, `last`/`burst_cnt` unchanged.
- Accepted word (valid & ready) is registered: next cycle `fifo_wr_en`=1, `fifo_data_in`=word, `grant_id`=granted index. Otherwise `fifo_wr_en`=0; `fifo_data_in`/`grant_id` hold last value.
- Response checking: `fifo_wr_ack` → `wr_count`+1. `fifo_overflow` → `ovf_err`=1 (word is lost, no retry). `clr_err` and `fifo_overflow` in same cycle → `ovf_err`=1 (set wins).
- `ready` never asserts without `valid` of that requester; at most one ready high per cycle.

## Timing
- Reset values: `fifo_wr_en`=0, `fifo_data_in`=0, `grant_id`=0, `wr_count`=0, `ovf_err`=0, `last`=1, `burst_cnt`=0; readies 0 while `rst_n` low.
- Acceptance in cycle c → `fifo_wr_en` in c+1 → FIFO writes at end of c+1 → `fifo_wr_ack` in c+2 → `wr_count` updates at end of c+2.
- Throughput: one word/cycle while `fifo_almostfull`=0; one word every 2 cycles while `almostfull`=1 and not full.
- Reset mid-operation: in-flight word on `fifo_wr_en` is abandoned immediately (async clear); responses arriving after reset release are counted normally.
- First grant after reset with both valid: requester 0.

## Test plan
- Fairness: both valid continuously, FIFO empty, BURST=4 → grant_id sequence 0,0,0,0,1,1,1,1,0… ; wr_count = words accepted after 2-cycle lag.
- Single requester: only req1 valid for 10 cycles → 10 back-to-back `fifo_wr_en` pulses, data in order, burst limit not applied.
- Near-full: drive `fifo_almostfull`=1, `fifo_full`=0 with req0 valid → `fifo_wr_en` pattern 1,0,1,0; set `fifo_full`=1 → no readies, `fifo_wr_en`=0 next cycle.
- Overflow check: inject `fifo_overflow`=1 one cycle → `ovf_err`=1 and stays; `clr_err` → 0; `clr_err` with `fifo_overflow` together → stays 1.
- Counter wrap: preload via 65536 `fifo_wr_ack` pulses → `wr_count` returns to 0.
- Async reset while `fifo_wr_en`=1 and burst_cnt=3 → all outputs to reset values within same cycle; after release with both valid, requester 0 granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Two-producer write arbiter for the SPI FIFO write port: burst-limited round-robin,
// flag-based overflow avoidance, registered write strobe, ack counting and sticky overflow flag.
module fifo_wr_arbiter #(
    parameter int WIDTH = 16,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             fifo_full,
    input  logic             fifo_almostfull,
    input  logic             fifo_wr_ack,
    input  logic             fifo_overflow,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_data_in,
    output logic             grant_id,
    output logic [15:0]      wr_count,
    output logic             ovf_err,
    input  logic             clr_err
);
    localparam logic [3:0] BURST_L = 4'(BURST);

    logic             can_issue, gnt_vld, gnt_id, keep;
    logic             last_q, last_d;
    logic [3:0]       burst_q, burst_d;
    logic             wr_en_q;
    logic [WIDTH-1:0] data_q;
    logic             gid_q;
    logic [15:0]      cnt_q;
    logic             ovf_q;

    always_comb begin
        // A write still in flight is not yet reflected in almostfull, so it would take the last slot.
        can_issue = !fifo_full && (!wr_en_q || !fifo_almostfull);
        gnt_vld   = 1'b0;
        gnt_id    = last_q;
        keep      = 1'b0;
        last_d    = last_q;
        burst_d   = burst_q;
        if (rst_n && can_issue) begin
            if (req0_valid && req1_valid) begin
                // burst_cnt==0 only before the first grant: no burst is owned, so requester 0 wins.
                keep    = (burst_q != 4'd0) && (burst_q < BURST_L);
                gnt_vld = 1'b1;
                gnt_id  = keep ? last_q : ~last_q;
            end else if (req0_valid || req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = req1_valid;
            end
        end
        if (gnt_vld) begin
            if (gnt_id == last_q) begin
                burst_d = (burst_q >= BURST_L) ? BURST_L : burst_q + 4'd1;
            end else begin
                last_d  = gnt_id;
                burst_d = 4'd1;
            end
        end
        req0_ready = gnt_vld && !gnt_id;
        req1_ready = gnt_vld && gnt_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            burst_q <= 4'd0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            gid_q   <= 1'b0;
            cnt_q   <= 16'd0;
            ovf_q   <= 1'b0;
        end else begin
            last_q  <= last_d;
            burst_q <= burst_d;
            wr_en_q <= gnt_vld;
            if (gnt_vld) begin
                data_q <= gnt_id ? req1_data : req0_data;
                gid_q  <= gnt_id;
            end
            if (fifo_wr_ack) cnt_q <= cnt_q + 16'd1;
            if (fifo_overflow)  ovf_q <= 1'b1;
            else if (clr_err)   ovf_q <= 1'b0;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign grant_id     = gid_q;
    assign wr_count     = cnt_q;
    assign ovf_err      = ovf_q;
endmodule
